// File: rtl/pwm_phase_monitor_if.sv
// Signal bundle between a multi-phase PWM source/observer and pwm_phase_monitor.
// master drives the PWM lines and tick enable; slave is the monitor.
interface pwm_phase_monitor_if #(
  parameter int unsigned NPHASES = 4,
  parameter int unsigned CNT_W   = 9
);
  logic                       en;
  logic [NPHASES-1:0]         pwm_ph;
  logic                       meas_valid;
  logic [CNT_W-1:0]           period_cnt;
  logic [NPHASES*CNT_W-1:0]   phase_dly;
  logic [NPHASES*CNT_W-1:0]   duty_cnt;
  logic                       phase_ok;
  logic                       timeout;

  modport master (
    output en, pwm_ph,
    input  meas_valid, period_cnt, phase_dly, duty_cnt, phase_ok, timeout
  );

  modport slave (
    input  en, pwm_ph,
    output meas_valid, period_cnt, phase_dly, duty_cnt, phase_ok, timeout
  );
endinterface

// File: rtl/pwm_phase_monitor.sv
// Per-period checker for phase-shifted PWM: measures period, per-phase rising-edge delay
// relative to phase 0 and per-phase high time, and flags deviation from ideal spacing.
module pwm_phase_monitor #(
  parameter int unsigned PERIOD  = 128,
  parameter int unsigned NPHASES = 4,
  parameter int unsigned CNT_W   = 9,
  parameter int unsigned TOL     = 2
) (
  input logic              clk,
  input logic              rst,
  pwm_phase_monitor_if.slave bus
);
  localparam int unsigned ErrW    = CNT_W + 1;
  localparam int unsigned Spacing = PERIOD / NPHASES;
  localparam logic [CNT_W-1:0]        CntMax      = '1;
  localparam logic [CNT_W-1:0]        TimeoutTick = CNT_W'(2 * PERIOD);
  localparam logic [CNT_W-1:0]        CntOne      = CNT_W'(1);
  localparam logic signed [ErrW-1:0]  TolS        = ErrW'(TOL);

  typedef enum logic [0:0] {StIdle, StMeas} state_e;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               tick_q, tick_d;
  logic [NPHASES-1:0]             prev_q, prev_d;
  // Bit 0 is set whenever a window opens so slice 0 publishes as a plain 0 delay.
  logic [NPHASES-1:0]             cap_q, cap_d;
  logic [NPHASES-1:0][CNT_W-1:0]  dly_q, dly_d;
  logic [NPHASES-1:0][CNT_W-1:0]  acc_q, acc_d;

  logic                           valid_q, valid_d;
  logic                           tmo_q, tmo_d;
  logic                           ok_q, ok_d;
  logic [CNT_W-1:0]               period_q, period_d;
  logic [NPHASES-1:0][CNT_W-1:0]  pdly_q, pdly_d;
  logic [NPHASES-1:0][CNT_W-1:0]  duty_q, duty_d;

  logic [NPHASES-1:0]             rise;
  logic                           open_win;
  logic                           ok_calc;

  function automatic logic within_tol(logic [CNT_W-1:0] meas, int unsigned ideal);
    logic signed [ErrW-1:0] err;
    err = $signed({1'b0, meas}) - $signed(ErrW'(ideal));
    return (err <= TolS) && (err >= -TolS);
  endfunction

  always_comb begin
    ok_calc = within_tol(tick_q, PERIOD);
    for (int unsigned k = 1; k < NPHASES; k++) begin
      if (!cap_q[k] || !within_tol(dly_q[k], k * Spacing)) begin
        ok_calc = 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    prev_d   = prev_q;
    cap_d    = cap_q;
    dly_d    = dly_q;
    acc_d    = acc_q;
    valid_d  = 1'b0;
    tmo_d    = 1'b0;
    ok_d     = ok_q;
    period_d = period_q;
    pdly_d   = pdly_q;
    duty_d   = duty_q;
    rise     = '0;
    open_win = 1'b0;

    if (bus.en) begin
      rise     = bus.pwm_ph & ~prev_q;
      prev_d   = bus.pwm_ph;
      open_win = rise[0];
      unique case (state_q)
        StIdle: ;
        StMeas: begin
          if (rise[0]) begin
            valid_d  = 1'b1;
            period_d = tick_q;
            ok_d     = ok_calc;
            for (int unsigned k = 0; k < NPHASES; k++) begin
              pdly_d[k] = cap_q[k] ? dly_q[k] : CntMax;
              duty_d[k] = acc_q[k];
            end
          end else if (tick_q == TimeoutTick) begin
            tmo_d   = 1'b1;
            state_d = StIdle;
          end else begin
            tick_d = tick_q + CntOne;
            for (int unsigned k = 0; k < NPHASES; k++) begin
              if (rise[k] && !cap_q[k]) begin
                cap_d[k] = 1'b1;
                dly_d[k] = tick_q;
              end
              if (bus.pwm_ph[k] && (acc_q[k] != CntMax)) begin
                acc_d[k] = acc_q[k] + CntOne;
              end
            end
          end
        end
        default: ;
      endcase
    end

    // A phase-0 edge opens a fresh window; coincident phase edges count as delay 0.
    if (open_win) begin
      state_d = StMeas;
      tick_d  = CntOne;
      cap_d   = rise;
      dly_d   = '0;
      for (int unsigned k = 0; k < NPHASES; k++) begin
        acc_d[k] = {{(CNT_W-1){1'b0}}, bus.pwm_ph[k]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      prev_q   <= '0;
      cap_q    <= '0;
      dly_q    <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
      ok_q     <= 1'b0;
      period_q <= '0;
      pdly_q   <= '0;
      duty_q   <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      prev_q   <= prev_d;
      cap_q    <= cap_d;
      dly_q    <= dly_d;
      acc_q    <= acc_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
      ok_q     <= ok_d;
      period_q <= period_d;
      pdly_q   <= pdly_d;
      duty_q   <= duty_d;
    end
  end

  assign bus.meas_valid = valid_q;
  assign bus.timeout    = tmo_q;
  assign bus.phase_ok   = ok_q;
  assign bus.period_cnt = period_q;
  assign bus.phase_dly  = pdly_q;
  assign bus.duty_cnt   = duty_q;

endmodule

// File: tb/tb_pwm_phase_monitor.sv
// Bench for pwm_phase_monitor: directed PWM periods, a window-sample model checked every
// cycle, and literal expectations on selected published periods.
module tb_pwm_phase_monitor;
  localparam int PER  = 128;
  localparam int NPH  = 4;
  localparam int CW   = 9;
  localparam int TOLB = 2;
  localparam int SENT = (1 << CW) - 1;

  logic clk;
  logic rst;

  pwm_phase_monitor_if #(.NPHASES(NPH), .CNT_W(CW)) bus ();

  pwm_phase_monitor #(
    .PERIOD(PER), .NPHASES(NPH), .CNT_W(CW), .TOL(TOLB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dly_of(input int k);
    return int'(bus.phase_dly[k*CW +: CW]);
  endfunction

  function automatic int duty_of(input int k);
    return int'(bus.duty_cnt[k*CW +: CW]);
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Model: keep every en-sample of the current window and derive results from them.
  int         e_valid = 0, e_tmo = 0, e_ok = 0, e_period = 0;
  int         e_dly[NPH];
  int         e_duty[NPH];
  logic [3:0] m_prev = '0;
  bit         m_armed = 0;
  logic [3:0] w_ph[$];
  logic [3:0] w_rise[$];
  int         cyc = 0;

  task automatic model_reset();
    e_valid = 0; e_tmo = 0; e_ok = 0; e_period = 0;
    for (int k = 0; k < NPH; k++) begin
      e_dly[k] = 0;
      e_duty[k] = 0;
    end
    m_prev = '0;
    m_armed = 0;
    w_ph.delete();
    w_rise.delete();
  endtask

  task automatic model_publish();
    int ok;
    int cnt;
    e_valid  = 1;
    e_period = w_ph.size();
    ok = (iabs(e_period - PER) <= TOLB);
    e_dly[0] = 0;
    for (int k = 1; k < NPH; k++) begin
      e_dly[k] = SENT;
      for (int j = 0; j < w_rise.size(); j++) begin
        if (w_rise[j][k]) begin
          e_dly[k] = j;
          break;
        end
      end
      if (e_dly[k] == SENT || iabs(e_dly[k] - k * (PER / NPH)) > TOLB) ok = 0;
    end
    for (int k = 0; k < NPH; k++) begin
      cnt = 0;
      foreach (w_ph[j]) cnt += int'(w_ph[j][k]);
      e_duty[k] = (cnt > SENT) ? SENT : cnt;
    end
    e_ok = ok;
  endtask

  task automatic model_step(input logic [3:0] ph);
    logic [3:0] r;
    r = ph & ~m_prev;
    m_prev = ph;
    if (r[0]) begin
      if (m_armed) model_publish();
      m_armed = 1;
      w_ph.delete();
      w_rise.delete();
      w_ph.push_back(ph);
      w_rise.push_back(r);
    end else if (m_armed) begin
      if (w_ph.size() == 2 * PER) begin
        e_tmo = 1;
        m_armed = 0;
        w_ph.delete();
        w_rise.delete();
      end else begin
        w_ph.push_back(ph);
        w_rise.push_back(r);
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        cyc++;
        e_valid = 0;
        e_tmo = 0;
        if (bus.en) model_step(bus.pwm_ph);
      end
    end
  end

  // Per-cycle compare on the falling edge, plus pulse bookkeeping for literal checks.
  int n_valid = 0;
  int n_tmo = 0;
  int tmo_cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("meas_valid", int'(bus.meas_valid), e_valid);
      chk("timeout", int'(bus.timeout), e_tmo);
      chk("phase_ok", int'(bus.phase_ok), e_ok);
      chk("period_cnt", int'(bus.period_cnt), e_period);
      for (int k = 0; k < NPH; k++) begin
        chk($sformatf("phase_dly[%0d]", k), dly_of(k), e_dly[k]);
        chk($sformatf("duty_cnt[%0d]", k), duty_of(k), e_duty[k]);
      end
      if (bus.meas_valid) n_valid++;
      if (bus.timeout) begin
        n_tmo++;
        tmo_cyc = cyc;
      end
    end
  end

  // Stimulus description of one period: phase k high on ticks [pd, pd+pw).
  int pd[NPH];
  int pw[NPH];
  int pd1b, pw1b, stall_at, stall_len, rst_at;
  int t0_cyc = 0;

  task automatic set_base();
    for (int k = 0; k < NPH; k++) begin
      pd[k] = k * (PER / NPH);
      pw[k] = PER / NPH;
    end
    pd1b = 0; pw1b = 0; stall_at = -1; stall_len = 0; rst_at = -1;
  endtask

  task automatic run_period(input int len);
    logic [3:0] v;
    for (int t = 0; t < len; t++) begin
      for (int k = 0; k < NPH; k++) v[k] = (t >= pd[k]) && (t < pd[k] + pw[k]);
      if (pw1b > 0 && t >= pd1b && t < pd1b + pw1b) v[1] = 1'b1;
      if (t == stall_at) begin
        bus.en = 1'b0;
        bus.pwm_ph = v;
        repeat (stall_len) @(negedge clk);
      end
      bus.en = 1'b1;
      bus.pwm_ph = v;
      if (t == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("async_rst meas_valid", int'(bus.meas_valid), 0);
        chk("async_rst period_cnt", int'(bus.period_cnt), 0);
        chk("async_rst phase_dly", int'(bus.phase_dly != '0), 0);
        chk("async_rst duty_cnt", int'(bus.duty_cnt != '0), 0);
        chk("async_rst phase_ok", int'(bus.phase_ok), 0);
        @(negedge clk);
        rst = 1'b0;
      end
      @(negedge clk);
      if (t == 0) t0_cyc = cyc;
    end
  endtask

  task automatic chk_result(input string tag, input int per, input int d1, input int d2,
                            input int d3, input int u0, input int u1, input int u2,
                            input int u3, input int ok);
    chk({tag, " period"}, int'(bus.period_cnt), per);
    chk({tag, " dly0"}, dly_of(0), 0);
    chk({tag, " dly1"}, dly_of(1), d1);
    chk({tag, " dly2"}, dly_of(2), d2);
    chk({tag, " dly3"}, dly_of(3), d3);
    chk({tag, " duty0"}, duty_of(0), u0);
    chk({tag, " duty1"}, duty_of(1), u1);
    chk({tag, " duty2"}, duty_of(2), u2);
    chk({tag, " duty3"}, duty_of(3), u3);
    chk({tag, " ok"}, int'(bus.phase_ok), ok);
  endtask

  int v_save;

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.pwm_ph = '0;
    repeat (3) @(negedge clk);
    chk("reset meas_valid", int'(bus.meas_valid), 0);
    chk("reset period_cnt", int'(bus.period_cnt), 0);
    chk("reset timeout", int'(bus.timeout), 0);
    rst = 1'b0;
    bus.en = 1'b1;
    repeat (4) @(negedge clk);

    set_base();
    run_period(PER);
    chk("arm no valid", n_valid, 0);
    run_period(PER);
    chk("first valid count", n_valid, 1);
    chk_result("base", 128, 32, 64, 96, 32, 32, 32, 32, 1);

    pd[2] = 69;
    run_period(PER);
    pd[2] = 66;
    run_period(PER);
    chk_result("dly69", 128, 32, 69, 96, 32, 32, 32, 32, 0);
    set_base();
    run_period(131);
    chk_result("dly66", 128, 32, 66, 96, 32, 32, 32, 32, 1);
    pw[3] = 0;
    run_period(PER);
    chk_result("per131", 131, 32, 64, 96, 32, 32, 32, 32, 0);
    pd[3] = 0;
    pw[3] = PER;
    run_period(PER);
    chk_result("ph3low", 128, 32, 64, SENT, 32, 32, 32, 0, 0);
    run_period(PER);
    chk_result("ph3high1", 128, 32, 64, 0, 32, 32, 32, 128, 0);
    set_base();
    pw[1] = 10;
    pd1b = 50;
    pw1b = 10;
    run_period(PER);
    chk_result("ph3high2", 128, 32, 64, SENT, 32, 32, 32, 128, 0);
    set_base();
    stall_at = 32;
    stall_len = 10;
    run_period(PER);
    chk_result("ph1twice", 128, 32, 64, 96, 32, 20, 32, 32, 1);

    set_base();
    pw[1] = 0; pw[2] = 0; pw[3] = 0;
    v_save = n_valid;
    run_period(300);
    chk("timeout count", n_tmo, 1);
    chk("timeout distance", tmo_cyc - t0_cyc, 2 * PER);
    chk("timeout no extra valid", n_valid, v_save + 1);
    chk_result("stall_hold", 128, 32, 64, 96, 32, 32, 32, 32, 1);
    set_base();
    run_period(PER);
    chk("rearm no valid", n_valid, v_save + 1);
    run_period(PER);
    chk("rearm valid", n_valid, v_save + 2);
    chk_result("rearm", 128, 32, 64, 96, 32, 32, 32, 32, 1);

    rst_at = 60;
    run_period(PER);
    v_save = n_valid;
    rst_at = -1;
    run_period(PER);
    chk("post_rst arm no valid", n_valid, v_save);
    run_period(PER);
    chk("post_rst valid", n_valid, v_save + 1);
    chk_result("post_rst", 128, 32, 64, 96, 32, 32, 32, 32, 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pwm_phase_monitor.md
Name: pwm_phase_monitor

Overview:
Receive-side checker for multi-phase PWM. It takes the NPHASES phase-shifted PWM lines that drive the power stages and measures, once per period, three things: the period length, each phase's rising-edge delay relative to phase 0, and each phase's high time. It reports the results with a valid pulse plus a pass/fail flag against the ideal k*PERIOD/NPHASES spacing. It sits beside the phase shifter for BIST and fault detection and shares its clock.

Parameters:
PERIOD, 128, nominal ticks per PWM period
NPHASES, 4, number of phases monitored (>=2)
CNT_W, 9, counter/result width; must satisfy 2^CNT_W > 2*PERIOD
TOL, 2, allowed absolute error in ticks for phase delay and period

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  tick enable; all state frozen when low
pwm_ph  input  NPHASES  phase PWM lines, bit k = phase k, synchronous to clk
meas_valid  output  1  one-cycle pulse; result outputs updated this cycle
period_cnt  output  CNT_W  measured ticks between consecutive phase-0 rising edges
phase_dly  output  NPHASES*CNT_W  slice k = delay of phase k; slice 0 always 0
duty_cnt  output  NPHASES*CNT_W  slice k = ticks phase k was high in the period
phase_ok  output  1  1 when the last published period passed all checks
timeout  output  1  one-cycle pulse when no phase-0 edge arrives within 2*PERIOD ticks

Behaviour:
- Reset (async, immediate):
  - All outputs 0.
  - State IDLE; tick counter, per-phase capture/accumulator registers and edge-detect history all 0.
- Edge detect: prev register of pwm_ph, updated only on en cycles. The rising edge of phase k is pwm_ph[k]=1 & prev[k]=0 on an en cycle.
- tick: ticks since the last phase-0 edge.
  - On a phase-0 edge, tick<=1.
  - Otherwise tick increments on en cycles.
- States:
  - IDLE: wait for a phase-0 edge, then go to MEAS. No publish.
  - MEAS, phase-0 edge:
    - Publish: meas_valid=1, period_cnt<=tick, plus captured delays, duty and phase_ok.
    - Clear captures and accumulators, restart tick, stay in MEAS.
  - MEAS, tick reaches 2*PERIOD with no phase-0 edge: timeout pulse for one cycle, go to IDLE. Outputs hold their last published values; nothing is published.
- Delay capture, phase k>=1:
  - On the first rising edge in the window, capture tick. Later edges in the same window are ignored.
  - If the edge coincides with a phase-0 edge, it belongs to the new window with delay 0.
  - No edge in the window: publish all-ones (2^CNT_W-1).
- Duty accumulation, every phase including 0: +1 per en cycle with pwm_ph[k]=1 while in MEAS, including the edge cycle that opens the window. Saturates at 2^CNT_W-1.
- phase_ok = 1 when all of the following hold:
  - |period_cnt - PERIOD| <= TOL.
  - For every k>=1, the delay is not the sentinel and |dly_k - k*(PERIOD/NPHASES)| <= TOL.
  - Signed compare, with widths extended by 1 bit.
- Outputs are registered. meas_valid appears in the cycle after the sampled phase-0 edge, i.e. 1 cycle of latency from the input edge.
- en low: tick, accumulators, prev and state all hold. No edges are detected and no timeout advances.
- First phase-0 edge after reset or after a timeout only arms the monitor; the first meas_valid comes at the second edge.

Test Plan:
- Drive the four lines with a 32-tick high pulse each, delays 0/32/64/96, period 128 -> first valid at the second phase-0 edge, then every 128 cycles. period_cnt=128, phase_dly={96,64,32,0}, duty_cnt=32 on each phase, phase_ok=1.
- Shift phase 2 to delay 69 -> phase_dly slice 2=69, phase_ok=0. Shift it to 66 instead -> 66, phase_ok=1 (TOL=2). Stretch the period to 131 -> period_cnt=131, phase_ok=0.
- Hold phase 3 low -> slice 3=511, duty slice 3=0, phase_ok=0. Phase 3 held high -> duty 128, delay 511. Two pulses on phase 1 at ticks 32 and 50 -> delay 32.
- Stop phase 0 after an edge -> timeout pulse 256 en-ticks later, no meas_valid, outputs keep their old values. Restart phase 0 -> first valid only at the second new edge.
- Deassert en for 10 cycles mid-period -> period_cnt=128 and duties unchanged versus the no-stall run. Phase-1 edge held pending during the stall and present at resume -> still detected, since prev is frozen.
- Assert rst asynchronously mid-period (off clock edge) -> all outputs 0 immediately. No meas_valid for the next phase-0 edge; valid resumes one period later.
